// File: rtl/counter_nbit.sv
// counter_nbit: WIDTH-bit up/down counter with modulus MAX_VAL+1.
// Optional saturation, parallel load and boundary-event reporting.
//
// Ports
//   clk        : sole clock, rising edge
//   reset_n    : synchronous active-low reset
//   en         : count enable, one step per enabled edge
//   up         : 1 = increment, 0 = decrement
//   load       : parallel load strobe, has priority over en
//   load_data  : value to load, clamped to MAX_VAL
//   clr_ovf    : clears ovf_sticky (a boundary event on the same edge wins)
//   count      : registered counter value
//   tc         : combinational terminal count for the current direction
//   wrap       : one-cycle pulse after each boundary-event edge
//   ovf_sticky : sticky boundary-event flag
module counter_nbit #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter int               SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             ovf_sticky
);

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             at_max, at_zero;
  logic             bnd_evt;
  logic [WIDTH-1:0] load_clamp;
  logic [WIDTH-1:0] count_nxt;

  assign at_max  = (count == MAX_VAL);
  assign at_zero = (count == ZERO);

  // Terminal count looks only at direction and value, never at en/load.
  assign tc = up ? at_max : at_zero;

  // A boundary event is an enabled step that would leave the 0..MAX_VAL range.
  assign bnd_evt = en & ~load & tc;

  // Loads above the modulus are clamped so count stays inside 0..MAX_VAL.
  assign load_clamp = (load_data > MAX_VAL) ? MAX_VAL : load_data;

  always_comb begin
    count_nxt = count;
    if (load) begin
      count_nxt = load_clamp;
    end else if (en) begin
      if (bnd_evt) begin
        if (SATURATE == 0) count_nxt = up ? ZERO : MAX_VAL;
      end else begin
        count_nxt = up ? (count + ONE) : (count - ONE);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count      <= ZERO;
      wrap       <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      count      <= count_nxt;
      wrap       <= bnd_evt;
      // Set beats clear when both happen on the same edge.
      ovf_sticky <= bnd_evt | (ovf_sticky & ~clr_ovf);
    end
  end

endmodule

// File: tb/tb_counter_nbit.sv
module tb_counter_nbit;

  logic        clk = 1'b0;
  logic        reset_n, en, up, load, clr_ovf;
  logic [31:0] load_data;

  logic [3:0]  c0, c1;
  logic [31:0] c2;
  logic        tc0, tc1, tc2, w0, w1, w2, o0, o1, o2;

  always #5 clk = ~clk;

  // 0: mod-10 wrapping, 1: mod-10 saturating, 2: full 32-bit wrapping
  counter_nbit #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(0)) d0 (
    .clk(clk), .reset_n(reset_n), .en(en), .up(up), .load(load),
    .load_data(load_data[3:0]), .clr_ovf(clr_ovf),
    .count(c0), .tc(tc0), .wrap(w0), .ovf_sticky(o0));

  counter_nbit #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1)) d1 (
    .clk(clk), .reset_n(reset_n), .en(en), .up(up), .load(load),
    .load_data(load_data[3:0]), .clr_ovf(clr_ovf),
    .count(c1), .tc(tc1), .wrap(w1), .ovf_sticky(o1));

  counter_nbit #(.WIDTH(32), .MAX_VAL(32'hFFFF_FFFF), .SATURATE(0)) d2 (
    .clk(clk), .reset_n(reset_n), .en(en), .up(up), .load(load),
    .load_data(load_data), .clr_ovf(clr_ovf),
    .count(c2), .tc(tc2), .wrap(w2), .ovf_sticky(o2));

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Counter as an integer in 0..maxv; a step that leaves that range is a
  // boundary event and is either folded back modulo (maxv+1) or clamped.
  longint mmax [3] = '{9, 9, 64'hFFFF_FFFF};
  bit     msat [3] = '{0, 1, 0};
  longint mmask[3] = '{15, 15, 64'hFFFF_FFFF};
  longint mcnt [3];
  bit     mwrap[3];
  bit     movf [3];
  bit     armed = 0;

  function automatic void mstep(input int k);
    longint nxt, ld;
    bit     ev;
    ev = 0;
    if (!reset_n) begin
      mcnt[k] = 0; mwrap[k] = 0; movf[k] = 0;
      return;
    end
    if (load) begin
      ld = longint'(load_data) & mmask[k];
      mcnt[k] = (ld > mmax[k]) ? mmax[k] : ld;
    end else if (en) begin
      nxt = up ? mcnt[k] + 1 : mcnt[k] - 1;
      if (nxt > mmax[k] || nxt < 0) begin
        ev = 1;
        if (msat[k]) nxt = mcnt[k];
        else if (nxt < 0) nxt = nxt + mmax[k] + 1;
        else nxt = nxt - (mmax[k] + 1);
      end
      mcnt[k] = nxt;
    end
    mwrap[k] = ev;
    movf[k]  = ev | (movf[k] & ~clr_ovf);
  endfunction

  // Compare on the falling edge: outputs reflect the last rising edge and
  // inputs already hold what the next rising edge will sample.
  always @(negedge clk) begin
    logic [31:0] ac [3];
    logic        at [3], aw [3], ao [3];
    ac = '{{28'b0, c0}, {28'b0, c1}, c2};
    at = '{tc0, tc1, tc2};
    aw = '{w0, w1, w2};
    ao = '{o0, o1, o2};
    if (armed) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("d%0d.count", k), ac[k], 32'(mcnt[k]));
        chk($sformatf("d%0d.tc", k), {31'b0, at[k]},
            {31'b0, up ? (mcnt[k] == mmax[k]) : (mcnt[k] == 0)});
        chk($sformatf("d%0d.wrap", k), {31'b0, aw[k]}, {31'b0, mwrap[k]});
        chk($sformatf("d%0d.ovf", k), {31'b0, ao[k]}, {31'b0, movf[k]});
      end
    end
    for (int k = 0; k < 3; k++) mstep(k);
    if (!reset_n) armed = 1;
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input logic e, input logic u, input logic l,
                      input logic [31:0] d, input logic c);
    en = e; up = u; load = l; load_data = d; clr_ovf = c;
    @(posedge clk); #1;
  endtask

  initial begin
    reset_n = 0; en = 0; up = 1; load = 0; load_data = 0; clr_ovf = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.count", {28'b0, c0}, 32'd0);
    chk("rst.wrap", {31'b0, w0}, 32'd0);
    chk("rst.ovf", {31'b0, o0}, 32'd0);
    chk("rst.tc_up", {31'b0, tc0}, 32'd0);
    up = 0; #1;
    chk("rst.tc_dn", {31'b0, tc0}, 32'd1);
    reset_n = 1;

    // count up 12: 1..9,0,1,2
    for (int i = 1; i <= 12; i++) begin
      step(1, 1, 0, 0, 0);
      chk($sformatf("up12.c%0d", i), {28'b0, c0}, 32'(i % 10));
      chk($sformatf("up12.w%0d", i), {31'b0, w0}, {31'b0, (i == 10)});
    end
    chk("up12.ovf", {31'b0, o0}, 32'd1);
    chk("up12.sat_cnt", {28'b0, c1}, 32'd9);

    // clamped load then count down 10: 8..0,9
    step(1, 1, 1, 32'hF, 0);
    chk("ld.clamp", {28'b0, c0}, 32'd9);
    chk("ld.wrap", {31'b0, w0}, 32'd0);
    for (int i = 1; i <= 10; i++) begin
      step(1, 0, 0, 0, 0);
      chk($sformatf("dn10.c%0d", i), {28'b0, c0}, (i == 10) ? 32'd9 : 32'(9 - i));
      chk($sformatf("dn10.w%0d", i), {31'b0, w0}, {31'b0, (i == 10)});
    end

    // saturating hold at 9, then step down
    step(0, 1, 1, 32'd9, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0, 0);
      chk("sat.cnt", {28'b0, c1}, 32'd9);
      chk("sat.wrap", {31'b0, w1}, 32'd1);
    end
    chk("sat.ovf", {31'b0, o1}, 32'd1);
    step(1, 0, 0, 0, 0);
    chk("sat.dn", {28'b0, c1}, 32'd8);
    chk("sat.dn_wrap", {31'b0, w1}, 32'd0);

    // set beats clear, then clear alone
    step(0, 1, 1, 32'd9, 1);
    step(1, 1, 0, 0, 1);
    chk("clr.cnt", {28'b0, c0}, 32'd0);
    chk("clr.set_wins", {31'b0, o0}, 32'd1);
    step(0, 1, 0, 0, 1);
    chk("clr.cleared", {31'b0, o0}, 32'd0);

    // reset beats load/en
    step(0, 1, 1, 32'd5, 0);
    chk("rl.pre", {28'b0, c0}, 32'd5);
    reset_n = 0;
    step(1, 1, 1, 32'd2, 0);
    chk("rl.cnt", {28'b0, c0}, 32'd0);
    chk("rl.wrap", {31'b0, w0}, 32'd0);
    chk("rl.ovf", {31'b0, o0}, 32'd0);
    reset_n = 1;
    step(0, 1, 1, 32'd2, 0);
    chk("rl.load", {28'b0, c0}, 32'd2);

    // 32-bit wrap both ways
    step(0, 1, 1, 32'hFFFF_FFFF, 0);
    step(1, 1, 0, 0, 0);
    chk("w32.up", c2, 32'd0);
    chk("w32.up_wrap", {31'b0, w2}, 32'd1);
    step(1, 0, 0, 0, 0);
    chk("w32.dn", c2, 32'hFFFF_FFFF);
    chk("w32.dn_wrap", {31'b0, w2}, 32'd1);

    step(0, 1, 0, 0, 0);
    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_nbit.md
COUNTER_NBIT -- requirements
Module: counter_nbit

Interface
REQ-001 Parameter WIDTH, default 8: counter width in bits; legal range 2..32.
REQ-002 Parameter MAX_VAL, default 2**WIDTH-1: terminal value (modulus minus one); legal range 1..2**WIDTH-1.
REQ-003 Parameter SATURATE, default 0: 0 = wrap at boundaries, 1 = hold at boundaries.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 en  input  1  count enable; one step per cycle while high.
REQ-007 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-008 load  input  1  synchronous parallel load strobe.
REQ-009 load_data  input  WIDTH  value to load.
REQ-010 clr_ovf  input  1  clears ovf_sticky.
REQ-011 count  output  WIDTH  registered counter value.
REQ-012 tc  output  1  combinational terminal-count flag.
REQ-013 wrap  output  1  registered one-cycle boundary-event pulse.
REQ-014 ovf_sticky  output  1  registered sticky boundary-event flag.

Function
REQ-015 Per-edge priority: reset_n low > load > en > hold.
REQ-016 load=1: count <= min(load_data, MAX_VAL); en and up ignored; wrap <= 0 that edge.
REQ-017 load=0, en=0: count, ovf_sticky hold; wrap <= 0.
REQ-018 en=1, up=1, count<MAX_VAL: count <= count+1; wrap <= 0.
REQ-019 en=1, up=0, count>0: count <= count-1; wrap <= 0.
REQ-020 Boundary event: en=1, load=0, and (up=1 with count==MAX_VAL) or (up=0 with count==0).
REQ-021 Boundary event, SATURATE=0: up wraps to 0, down wraps to MAX_VAL; wrap <= 1.
REQ-022 Boundary event, SATURATE=1: count holds; wrap <= 1.
REQ-023 wrap is high for exactly the one cycle following each boundary-event edge; consecutive boundary events keep it high on consecutive cycles.
REQ-024 tc = (up & count==MAX_VAL) | (~up & count==0), independent of en and load.
REQ-025 ovf_sticky <= 1 on any boundary-event edge; clr_ovf=1 with no boundary event clears it; simultaneous set and clear -> set wins.
REQ-026 Arithmetic is WIDTH-bit unsigned; count never exceeds MAX_VAL in any reachable state.
REQ-027 Direction change takes effect on the next enabled edge, with no extra latency.
REQ-028 Count-update latency is one clock: inputs sampled at edge N are reflected in count after edge N.

Reset
REQ-029 reset_n=0 at a rising edge: count <= 0, wrap <= 0, ovf_sticky <= 0, regardless of load/en/clr_ovf.
REQ-030 Reset asserted mid-count or mid-load aborts the operation; the first edge with reset_n=1 resumes from count=0.
REQ-031 No output changes asynchronously on reset_n; tc follows the reset count combinationally (up=1 -> 0, up=0 -> 1).

Verification (WIDTH=4, MAX_VAL=9 unless noted)
REQ-032 Reset, then en=1, up=1 for 12 cycles -> count 1..9,0,1,2; wrap high only the cycle count=0 appears; tc high while count=9; ovf_sticky=1 from then on.
REQ-033 Load 4'hF with en=1 -> count=9 (clamped), wrap=0; then up=0, en=1 for 10 cycles -> count 8..0,9; wrap pulses once on the 0->9 edge.
REQ-034 SATURATE=1, count=9, up=1, en=1 for 3 cycles -> count stays 9, wrap high 3 consecutive cycles, ovf_sticky=1; then up=0 for 1 cycle -> count=8, wrap=0.
REQ-035 count=9, up=1, en=1, clr_ovf=1 on the same edge -> count=0, ovf_sticky=1; clr_ovf=1 on the next edge with en=0 -> ovf_sticky=0.
REQ-036 count=5, en=1, load=1, load_data=2, reset_n=0 on the same edge -> count=0, wrap=0, ovf_sticky=0; next edge with reset_n=1, load=1 -> count=2.
REQ-037 WIDTH=32, MAX_VAL=2**32-1, SATURATE=0: load 32'hFFFFFFFF, en=1, up=1 -> count=0, wrap=1; up=0 next edge -> count=32'hFFFFFFFF, wrap=1.
